// File: rtl/pwm_gen_pkg.sv
// Shared types, constants and helpers for the PWM generator core.
package pwm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_e;

  localparam int unsigned PWM_NB_PULSES_W = 32;
  localparam logic [PWM_NB_PULSES_W-1:0] NB_PULSES_MAX = '1;

  // Widest supported field and bus (16 channels of up to 64 bits).
  localparam int unsigned CFG_FIELD_MAX_W = 64;
  localparam int unsigned CFG_BUS_MAX_W   = 16 * CFG_FIELD_MAX_W;

  // Extract channel k's field of width pw from a zero-extended packed cfg bus.
  // The caller truncates the result to its own field width.
  function automatic logic [CFG_FIELD_MAX_W-1:0] cfg_field(
    input logic [CFG_BUS_MAX_W-1:0] bus,
    input int unsigned              k,
    input int unsigned              pw
  );
    return CFG_FIELD_MAX_W'(bus >> (k * pw));
  endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Register-bank <-> PWM core connection: staged config, control and status.
interface pwm_gen_if import pwm_gen_pkg::*; #(
  parameter int unsigned N_PWMS      = 4,
  parameter int unsigned PULSE_WIDTH = 32
);

  logic                              sw_reset;
  logic                              load_config;
  logic [N_PWMS*PULSE_WIDTH-1:0]     cfg_period;
  logic [N_PWMS*PULSE_WIDTH-1:0]     cfg_width;
  logic [N_PWMS*PULSE_WIDTH-1:0]     cfg_offset;
  logic [N_PWMS-1:0]                 pwm;
  logic [PWM_NB_PULSES_W-1:0]        nb_pulses;
  logic                              cfg_pending;
  logic                              running;

  modport master (
    output sw_reset, load_config, cfg_period, cfg_width, cfg_offset,
    input  pwm, nb_pulses, cfg_pending, running
  );

  modport slave (
    input  sw_reset, load_config, cfg_period, cfg_width, cfg_offset,
    output pwm, nb_pulses, cfg_pending, running
  );

endinterface

// File: rtl/pwm_gen_channel.sv
// One PWM channel: active period/width/offset, offset and period counters,
// registered output. wrap flags the last cycle of the period.
module pwm_gen_channel import pwm_gen_pkg::*; #(
  parameter int unsigned PULSE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   enable,
  input  logic [PULSE_WIDTH-1:0] cfg_period,
  input  logic [PULSE_WIDTH-1:0] cfg_width,
  input  logic [PULSE_WIDTH-1:0] cfg_offset,
  output logic                   pwm,
  output logic                   wrap
);

  localparam logic [PULSE_WIDTH-1:0] ONE = PULSE_WIDTH'(1);

  logic [PULSE_WIDTH-1:0] period_q, period_d;
  logic [PULSE_WIDTH-1:0] width_q, width_d;
  logic [PULSE_WIDTH-1:0] offset_q, offset_d;
  logic [PULSE_WIDTH-1:0] off_cnt_q, off_cnt_d;
  logic [PULSE_WIDTH-1:0] cnt_q, cnt_d;
  logic                   pwm_q, pwm_d;
  logic                   off_done;
  logic                   at_last;

  assign off_done = (off_cnt_q == offset_q);
  assign at_last  = (cnt_q == period_q - ONE);
  // A disabled channel reports a boundary every cycle so reloads are never stalled.
  assign wrap     = (period_q == '0) || (off_done && at_last);
  assign pwm      = pwm_q;

  // Next-state: load > clear > count.
  always_comb begin
    period_d  = period_q;
    width_d   = width_q;
    offset_d  = offset_q;
    off_cnt_d = off_cnt_q;
    cnt_d     = cnt_q;
    pwm_d     = pwm_q;
    if (load) begin
      period_d  = cfg_period;
      width_d   = cfg_width;
      offset_d  = cfg_offset;
      off_cnt_d = '0;
      cnt_d     = '0;
      pwm_d     = 1'b0;
    end else if (clear) begin
      off_cnt_d = '0;
      cnt_d     = '0;
      pwm_d     = 1'b0;
    end else if (enable) begin
      if (!off_done) begin
        off_cnt_d = off_cnt_q + ONE;
        pwm_d     = 1'b0;
      end else if (period_q == '0) begin
        pwm_d = 1'b0;
      end else begin
        pwm_d = (cnt_q < width_q);
        cnt_d = at_last ? '0 : cnt_q + ONE;
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_q  <= '0;
      width_q   <= '0;
      offset_q  <= '0;
      off_cnt_q <= '0;
      cnt_q     <= '0;
      pwm_q     <= 1'b0;
    end else begin
      period_q  <= period_d;
      width_q   <= width_d;
      offset_q  <= offset_d;
      off_cnt_q <= off_cnt_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
    end
  end

endmodule

// File: rtl/pwm_gen_core.sv
// PWM counter engine: sequencing FSM, atomic config reload, N channels and
// channel-0 pulse counter.
module pwm_gen_core import pwm_gen_pkg::*; #(
  parameter int unsigned N_PWMS      = 4,
  parameter int unsigned PULSE_WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  pwm_gen_if.slave bus
);

  state_e                      state_q, state_d;
  logic                        running_q, running_d;
  logic                        pending_q, pending_d;
  logic                        pwm0_prev_q, pwm0_prev_d;
  logic [PWM_NB_PULSES_W-1:0]  nb_pulses_q, nb_pulses_d;

  logic [N_PWMS-1:0]           pwm_ch;
  logic [N_PWMS-1:0]           wrap_ch;
  logic                        idle_exit;
  logic                        apply;
  logic                        ch_load;
  logic                        run_en;
  logic                        unused_wrap;

  logic [CFG_BUS_MAX_W-1:0]    period_ext;
  logic [CFG_BUS_MAX_W-1:0]    width_ext;
  logic [CFG_BUS_MAX_W-1:0]    offset_ext;

  assign period_ext = CFG_BUS_MAX_W'(bus.cfg_period);
  assign width_ext  = CFG_BUS_MAX_W'(bus.cfg_width);
  assign offset_ext = CFG_BUS_MAX_W'(bus.cfg_offset);

  // Only channel 0's period boundary schedules reloads.
  assign unused_wrap = ^wrap_ch;

  // Reload qualification: IDLE exit, or a pending/new request at channel 0's boundary.
  always_comb begin
    idle_exit = !bus.sw_reset && (state_q == IDLE);
    apply     = !bus.sw_reset && (state_q == RUN) &&
                (pending_q || bus.load_config) && wrap_ch[0];
    ch_load   = idle_exit || apply;
    run_en    = (state_q == RUN);
  end

  for (genvar k = 0; k < N_PWMS; k++) begin : g_ch
    logic [PULSE_WIDTH-1:0] period_k;
    logic [PULSE_WIDTH-1:0] width_k;
    logic [PULSE_WIDTH-1:0] offset_k;

    assign period_k = PULSE_WIDTH'(cfg_field(period_ext, k, PULSE_WIDTH));
    assign width_k  = PULSE_WIDTH'(cfg_field(width_ext, k, PULSE_WIDTH));
    assign offset_k = PULSE_WIDTH'(cfg_field(offset_ext, k, PULSE_WIDTH));

    pwm_gen_channel #(.PULSE_WIDTH(PULSE_WIDTH)) u_ch (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (bus.sw_reset),
      .load       (ch_load),
      .enable     (run_en),
      .cfg_period (period_k),
      .cfg_width  (width_k),
      .cfg_offset (offset_k),
      .pwm        (pwm_ch[k]),
      .wrap       (wrap_ch[k])
    );
  end

  // FSM, pending request and pulse counter next-state; sw_reset overrides all.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    nb_pulses_d = nb_pulses_q;
    pwm0_prev_d = pwm_ch[0];
    if (bus.sw_reset) begin
      state_d     = IDLE;
      pending_d   = 1'b0;
      nb_pulses_d = '0;
      pwm0_prev_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ALIGN;
        ALIGN:   state_d = RUN;
        RUN:     if (apply) state_d = ALIGN;
        default: state_d = IDLE;
      endcase
      if (ch_load) begin
        pending_d = 1'b0;
      end else if (bus.load_config) begin
        pending_d = 1'b1;
      end
      if (pwm0_prev_q && !pwm_ch[0] && (nb_pulses_q != NB_PULSES_MAX)) begin
        nb_pulses_d = nb_pulses_q + PWM_NB_PULSES_W'(1);
      end
    end
    running_d = (state_d == RUN);
  end

  // Core control registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      running_q   <= 1'b0;
      pending_q   <= 1'b0;
      pwm0_prev_q <= 1'b0;
      nb_pulses_q <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      pending_q   <= pending_d;
      pwm0_prev_q <= pwm0_prev_d;
      nb_pulses_q <= nb_pulses_d;
    end
  end

  assign bus.pwm         = pwm_ch;
  assign bus.nb_pulses   = nb_pulses_q;
  assign bus.cfg_pending = pending_q;
  assign bus.running     = running_q;

endmodule

// File: doc/pwm_gen_core.md
Name: pwm_gen_core

Overview:
- Counter engine behind the axi_pwm_gen register map. Consumes the PULSE_X_PERIOD/WIDTH/OFFSET, RESET and LOAD_CONFIG fields, produces N_PWMS phase-aligned PWM outputs, and returns the NB_PULSES count.
- Sits directly downstream of the AXI register bank, in the same clock domain.
- Staged configuration is applied atomically, with all channels resynchronised.

Parameters:
- N_PWMS, 4, number of PWM channels (1..16).
- PULSE_WIDTH, 32, width of the period/width/offset fields and counters.

Ports:
- clk  in  1  core clock
- resetn  in  1  reset; synchronous to clk, active-low
- sw_reset  in  1  REG_RSTN.RESET level; 1 holds the core idle
- load_config  in  1  one-cycle pulse from the REG_RSTN.LOAD_CONFIG write
- cfg_period  in  N_PWMS*PULSE_WIDTH  staged periods; channel k at [k*PW +: PW]
- cfg_width  in  N_PWMS*PULSE_WIDTH  staged high times
- cfg_offset  in  N_PWMS*PULSE_WIDTH  staged start offsets
- pwm  out  N_PWMS  registered PWM outputs
- nb_pulses  out  32  completed pulses on channel 0; drives REG_NB_PULSES
- cfg_pending  out  1  load request latched, not yet applied
- running  out  1  core in RUN state

Behaviour:
- Reset (resetn=0 at a clk edge):
  - pwm=0, nb_pulses=0, cfg_pending=0, running=0.
  - Active registers are cleared to 0. State=IDLE.
- States:
  - IDLE -> ALIGN when sw_reset=0. On entry to ALIGN, the staged cfg_* are copied to the active registers (apply cycle t0).
  - ALIGN -> RUN after one cycle.
  - Any state -> IDLE when sw_reset=1. IDLE has priority over every other event.
- sw_reset mid-operation:
  - pwm=0 on the next edge; all counters clear; cfg_pending clears; nb_pulses clears.
  - Active registers are retained until the next IDLE exit.
- Channel k, from t0:
  - The offset counter counts offset_k cycles, then the period counter starts at 0.
  - The period counter counts 0..period_k-1 and wraps.
  - pwm[k]=1 while cnt < width_k.
  - The first high cycle of pwm[k] is t0+2+offset_k. This is fixed latency; offset=0 gives t0+2.
- Boundaries:
  - period_k=0: channel disabled, pwm[k]=0 permanently.
  - width_k=0: pwm[k]=0.
  - width_k>=period_k (period>0): pwm[k]=1 continuously after the offset.
  - period_k=1 with width_k=1: constant 1.
- load_config:
  - Sets cfg_pending. Ignored while sw_reset=1. A repeat pulse while pending is absorbed and stays a single request.
  - If pending, or if load_config is asserted in the same cycle as the event, the request is applied on the cycle channel 0's period counter wraps (cnt=period_0-1).
  - If period_0=0, the request is applied on the next cycle.
  - Apply = copy staged -> active, clear all offset/period counters, pwm=0 for one cycle, clear cfg_pending, re-enter ALIGN. This is the new t0.
- nb_pulses:
  - Increments on each falling edge of pwm[0] (high->low transition of the registered output). Saturates at 0xFFFFFFFF.
  - Not cleared by load_config.
- Arithmetic:
  - Counters are PULSE_WIDTH bits, unsigned.
  - Comparisons are unsigned; no overflow is possible because cnt < period.
- Staged inputs are sampled only at apply cycles. Changing them between applies has no effect.

Decomposition:
- Package pwm_gen_pkg:
  - state enum (IDLE, ALIGN, RUN)
  - PWM_NB_PULSES_W=32
  - NB_PULSES_MAX constant
  - field-slice helper function for channel k of a packed cfg bus
- Sub-module pwm_gen_channel:
  - Holds one channel's active period/width/offset registers, offset counter, period counter and pwm register.
  - Inputs: clk, resetn, clear, load, cfg triplet. Outputs: pwm, wrap.
  - The top instantiates N_PWMS channels plus the state machine, pending logic and nb_pulses counter.

Test Plan:
- Reset, then sw_reset=0 with ch0 period=10, width=3, offset=0 -> pwm[0] high at t0+2..t0+4, low t0+5..t0+11, repeating with period 10. nb_pulses=1 after the first falling edge.
- ch1 period=10, width=5, offset=4 alongside ch0 -> pwm[1] first high at t0+6. Rising edges of pwm[1] lag pwm[0] by exactly 4 cycles every period.
- Running ch0 period=10, width=3. Stage period=20, width=7. Pulse load_config mid-period -> cfg_pending=1, old waveform completes; apply on the ch0 wrap, one low cycle, new waveform with period 20, width 7, cfg_pending=0.
- ch2 period=0 and ch3 width=12, period=8 -> pwm[2] stays 0; pwm[3] stays 1 after its offset. nb_pulses is unaffected by these channels.
- Assert sw_reset for 1 cycle mid-pulse -> all pwm=0 and nb_pulses=0 next edge. After release, the waveform restarts from a new t0 using the current staged values.
- Force nb_pulses near saturation (run ch0 period=2, width=1 with counter preloaded via backdoor to 0xFFFFFFFE) -> reaches 0xFFFFFFFF and holds.
